id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage_pkg.sv | 29 ++
 rtl/id_ex_stage_operand_forward.sv | 40 ++++
 rtl/id_ex_stage.sv | 156 +++++++++++++++
 tb/tb_id_ex_stage.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared ALU control encodings and operand-forward select codes.
// Imported by the ALU and by the ID/EX stage.
package id_ex_stage_pkg;

    localparam int unsigned ALU_CTRL_W = 16;

    localparam logic [ALU_CTRL_W-1:0] ALU_NOP = 16'h0000;
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 16'h0001;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 16'h0002;
    localparam logic [ALU_CTRL_W-1:0] ALU_AND = 16'h0004;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 16'h0008;
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR = 16'h0010;

    typedef enum logic [1:0] {
        FWD_REG   = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_WB    = 2'd2
    } fwd_sel_e;

    // x0 is hard-wired zero, so it never counts as a producer match.
    function automatic logic fwd_hit(
        input logic       we,
        input logic [4:0] rd,
        input logic [4:0] rs
    );
        return we && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/id_ex_stage_operand_forward.sv
// Per-source-register forward select and mux.
// EX/MEM result wins over MEM/WB result.
module operand_forward
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [4:0]      i_rsAddr,
    input  logic [XLEN-1:0] i_regData,
    input  logic            i_exMemRegWrite,
    input  logic [4:0]      i_exMemRdAddr,
    input  logic [XLEN-1:0] i_exMemResult,
    input  logic            i_wbRegWrite,
    input  logic [4:0]      i_wbRdAddr,
    input  logic [XLEN-1:0] i_wbResult,
    output logic [XLEN-1:0] o_data
);

    fwd_sel_e w_sel;

    always_comb begin
        w_sel = FWD_REG;
        if (fwd_hit(i_exMemRegWrite, i_exMemRdAddr, i_rsAddr)) begin
            w_sel = FWD_EXMEM;
        end else if (fwd_hit(i_wbRegWrite, i_wbRdAddr, i_rsAddr)) begin
            w_sel = FWD_WB;
        end
    end

    always_comb begin
        o_data = i_regData;
        unique case (w_sel)
            FWD_EXMEM: o_data = i_exMemResult;
            FWD_WB:    o_data = i_wbResult;
            FWD_REG:   o_data = i_regData;
            default:   o_data = i_regData;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and operand forwarding.
// ALU operands are driven combinationally from the held instruction.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inValid,
    output logic              inReady,
    input  logic [XLEN-1:0]   inPc,
    input  logic [XLEN-1:0]   inRs1Data,
    input  logic [XLEN-1:0]   inRs2Data,
    input  logic [XLEN-1:0]   inImm,
    input  logic [4:0]        inRs1Addr,
    input  logic [4:0]        inRs2Addr,
    input  logic [4:0]        inRdAddr,
    input  logic [CTRL_W-1:0] inAluCtrl,
    input  logic              inUsePc,
    input  logic              inUseImm,
    input  logic              inRegWrite,
    input  logic              inMemRead,
    input  logic              inMemWrite,
    input  logic              flush,
    input  logic              exMemRegWrite,
    input  logic [4:0]        exMemRdAddr,
    input  logic [XLEN-1:0]   exMemResult,
    input  logic              wbRegWrite,
    input  logic [4:0]        wbRdAddr,
    input  logic [XLEN-1:0]   wbResult,
    output logic              outValid,
    input  logic              outReady,
    output logic [XLEN-1:0]   aluA,
    output logic [XLEN-1:0]   aluB,
    output logic [CTRL_W-1:0] aluCtrl,
    output logic [XLEN-1:0]   outPc,
    output logic [XLEN-1:0]   outStoreData,
    output logic [4:0]        outRdAddr,
    output logic              outRegWrite,
    output logic              outMemRead,
    output logic              outMemWrite
);

    logic              r_valid;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_rs1Data;
    logic [XLEN-1:0]   r_rs2Data;
    logic [XLEN-1:0]   r_imm;
    logic [4:0]        r_rs1Addr;
    logic [4:0]        r_rs2Addr;
    logic [4:0]        r_rdAddr;
    logic [CTRL_W-1:0] r_aluCtrl;
    logic              r_usePc;
    logic              r_useImm;
    logic              r_regWrite;
    logic              r_memRead;
    logic              r_memWrite;

    logic              w_hazard;
    logic              w_xfer;
    logic [XLEN-1:0]   w_fwdRs1;
    logic [XLEN-1:0]   w_fwdRs2;
    logic [XLEN-1:0]   w_capRs1;
    logic [XLEN-1:0]   w_capRs2;

    // A held load cannot feed a dependent yet; stall it one cycle.
    assign w_hazard = r_valid && r_memRead && (r_rdAddr != 5'd0) && inValid
                   && ((inRs1Addr == r_rdAddr) || (inRs2Addr == r_rdAddr));
    assign inReady  = (!r_valid || outReady) && !w_hazard;
    assign w_xfer   = inValid && inReady;

    assign w_capRs1 = fwd_hit(wbRegWrite, wbRdAddr, inRs1Addr)
                    ? wbResult : inRs1Data;
    assign w_capRs2 = fwd_hit(wbRegWrite, wbRdAddr, inRs2Addr)
                    ? wbResult : inRs2Data;

    operand_forward #(.XLEN(XLEN)) u_fwd_rs1 (
        .i_rsAddr        (r_rs1Addr),
        .i_regData       (r_rs1Data),
        .i_exMemRegWrite (exMemRegWrite),
        .i_exMemRdAddr   (exMemRdAddr),
        .i_exMemResult   (exMemResult),
        .i_wbRegWrite    (wbRegWrite),
        .i_wbRdAddr      (wbRdAddr),
        .i_wbResult      (wbResult),
        .o_data          (w_fwdRs1)
    );

    operand_forward #(.XLEN(XLEN)) u_fwd_rs2 (
        .i_rsAddr        (r_rs2Addr),
        .i_regData       (r_rs2Data),
        .i_exMemRegWrite (exMemRegWrite),
        .i_exMemRdAddr   (exMemRdAddr),
        .i_exMemResult   (exMemResult),
        .i_wbRegWrite    (wbRegWrite),
        .i_wbRdAddr      (wbRdAddr),
        .i_wbResult      (wbResult),
        .o_data          (w_fwdRs2)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rs1Data  <= '0;
            r_rs2Data  <= '0;
            r_imm      <= '0;
            r_rs1Addr  <= '0;
            r_rs2Addr  <= '0;
            r_rdAddr   <= '0;
            r_aluCtrl  <= CTRL_W'(ALU_NOP);
            r_usePc    <= 1'b0;
            r_useImm   <= 1'b0;
            r_regWrite <= 1'b0;
            r_memRead  <= 1'b0;
            r_memWrite <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_xfer) begin
            r_valid    <= 1'b1;
            r_pc       <= inPc;
            r_rs1Data  <= w_capRs1;
            r_rs2Data  <= w_capRs2;
            r_imm      <= inImm;
            r_rs1Addr  <= inRs1Addr;
            r_rs2Addr  <= inRs2Addr;
            r_rdAddr   <= inRdAddr;
            r_aluCtrl  <= inAluCtrl;
            r_usePc    <= inUsePc;
            r_useImm   <= inUseImm;
            r_regWrite <= inRegWrite;
            r_memRead  <= inMemRead;
            r_memWrite <= inMemWrite;
        end else if (outReady || !r_valid) begin
            r_valid <= 1'b0;
        end else begin
            // Stalled: absorb producers now so none retire unseen.
            r_rs1Data <= w_fwdRs1;
            r_rs2Data <= w_fwdRs2;
        end
    end

    assign outValid     = r_valid;
    assign aluA         = r_usePc  ? r_pc  : w_fwdRs1;
    assign aluB         = r_useImm ? r_imm : w_fwdRs2;
    assign aluCtrl      = r_aluCtrl;
    assign outPc        = r_pc;
    assign outStoreData = w_fwdRs2;
    assign outRdAddr    = r_rdAddr;
    assign outRegWrite  = r_regWrite;
    assign outMemRead   = r_memRead;
    assign outMemWrite  = r_memWrite;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed vector table plus hand-written stall/flush/reset sequences.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        inValid;
    logic        inReady;
    logic [31:0] inPc, inRs1Data, inRs2Data, inImm;
    logic [4:0]  inRs1Addr, inRs2Addr, inRdAddr;
    logic [15:0] inAluCtrl;
    logic        inUsePc, inUseImm, inRegWrite, inMemRead, inMemWrite;
    logic        flush;
    logic        exMemRegWrite;
    logic [4:0]  exMemRdAddr;
    logic [31:0] exMemResult;
    logic        wbRegWrite;
    logic [4:0]  wbRdAddr;
    logic [31:0] wbResult;
    logic        outValid;
    logic        outReady;
    logic [31:0] aluA, aluB, outPc, outStoreData;
    logic [15:0] aluCtrl;
    logic [4:0]  outRdAddr;
    logic        outRegWrite, outMemRead, outMemWrite;

    int n_vec = 0;
    int n_bad = 0;

    id_ex_stage #(.XLEN(32), .CTRL_W(16)) dut (
        .clk(clk), .rst(rst),
        .inValid(inValid), .inReady(inReady),
        .inPc(inPc), .inRs1Data(inRs1Data), .inRs2Data(inRs2Data),
        .inImm(inImm), .inRs1Addr(inRs1Addr), .inRs2Addr(inRs2Addr),
        .inRdAddr(inRdAddr), .inAluCtrl(inAluCtrl),
        .inUsePc(inUsePc), .inUseImm(inUseImm),
        .inRegWrite(inRegWrite), .inMemRead(inMemRead),
        .inMemWrite(inMemWrite), .flush(flush),
        .exMemRegWrite(exMemRegWrite), .exMemRdAddr(exMemRdAddr),
        .exMemResult(exMemResult), .wbRegWrite(wbRegWrite),
        .wbRdAddr(wbRdAddr), .wbResult(wbResult),
        .outValid(outValid), .outReady(outReady),
        .aluA(aluA), .aluB(aluB), .aluCtrl(aluCtrl),
        .outPc(outPc), .outStoreData(outStoreData),
        .outRdAddr(outRdAddr), .outRegWrite(outRegWrite),
        .outMemRead(outMemRead), .outMemWrite(outMemWrite)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, d1, d2, imm;
        logic [4:0]  rs1, rs2;
        logic        usePc, useImm;
        logic [15:0] ctrl;
        logic        exW;
        logic [4:0]  exRd;
        logic [31:0] exRes;
        logic        wbW;
        logic [4:0]  wbRd;
        logic [31:0] wbRes;
        logic [31:0] eA, eB, eS;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_fwd();
        exMemRegWrite = 0; exMemRdAddr = 0; exMemResult = 0;
        wbRegWrite = 0; wbRdAddr = 0; wbResult = 0;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] imm, input logic upc,
                         input logic uimm, input logic mrd);
        inValid = 1; inPc = pc; inRs1Addr = rs1; inRs2Addr = rs2;
        inRdAddr = rd; inRs1Data = d1; inRs2Data = d2; inImm = imm;
        inUsePc = upc; inUseImm = uimm; inMemRead = mrd;
        inRegWrite = 1; inMemWrite = 0; inAluCtrl = 16'h0001;
    endtask

    initial begin
        rst = 1; inValid = 0; flush = 0; outReady = 1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        inValid = 0;
        idle_fwd();

        vecs[0] = '{32'h100, 32'h11, 32'h22, 32'h0, 5'd1, 5'd2, 0, 0,
                    16'h0001, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0,
                    32'h11, 32'h22, 32'h22};
        vecs[1] = '{32'h200, 32'h0, 32'h33, 32'h8, 5'd1, 5'd3, 1, 1,
                    16'h0002, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0,
                    32'h200, 32'h8, 32'h33};
        vecs[2] = '{32'h204, 32'h1, 32'h5, 32'h0, 5'd4, 5'd5, 0, 0,
                    16'h0004, 1, 5'd4, 32'hAAAA, 0, 5'd0, 32'h0,
                    32'hAAAA, 32'h5, 32'h5};
        vecs[3] = '{32'h208, 32'h66, 32'h9, 32'h0, 5'd6, 5'd2, 0, 0,
                    16'h0008, 1, 5'd2, 32'h1, 1, 5'd2, 32'h2,
                    32'h66, 32'h1, 32'h1};
        vecs[4] = '{32'h20C, 32'h7, 32'h9, 32'h0, 5'd0, 5'd0, 0, 0,
                    16'h0010, 1, 5'd0, 32'hFFFF, 1, 5'd0, 32'hFFFF,
                    32'h7, 32'h9, 32'h9};
        vecs[5] = '{32'h210, 32'h1, 32'h2, 32'h0, 5'd8, 5'd9, 0, 0,
                    16'h0001, 0, 5'd0, 32'h0, 1, 5'd8, 32'hBEEF,
                    32'hBEEF, 32'h2, 32'h2};
        vecs[6] = '{32'h214, 32'h44, 32'h3, 32'h0, 5'd10, 5'd11, 0, 0,
                    16'h0001, 0, 5'd0, 32'h0, 0, 5'd10, 32'h123,
                    32'h44, 32'h3, 32'h3};

        #12;
        chk("reset_outValid", {31'b0, outValid}, 0);
        chk("reset_aluA", aluA, 0);
        chk("reset_aluB", aluB, 0);
        chk("reset_aluCtrl", {16'b0, aluCtrl}, 0);
        chk("reset_storeData", outStoreData, 0);
        @(negedge clk);
        rst = 0;
        tick();

        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].pc, vecs[i].rs1, vecs[i].rs2, 5'd12,
                  vecs[i].d1, vecs[i].d2, vecs[i].imm,
                  vecs[i].usePc, vecs[i].useImm, 0);
            inAluCtrl = vecs[i].ctrl;
            exMemRegWrite = vecs[i].exW; exMemRdAddr = vecs[i].exRd;
            exMemResult = vecs[i].exRes;
            wbRegWrite = vecs[i].wbW; wbRdAddr = vecs[i].wbRd;
            wbResult = vecs[i].wbRes;
            #1;
            chk($sformatf("v%0d_inReady", i), {31'b0, inReady}, 1);
            tick();
            chk($sformatf("v%0d_outValid", i), {31'b0, outValid}, 1);
            chk($sformatf("v%0d_aluA", i), aluA, vecs[i].eA);
            chk($sformatf("v%0d_aluB", i), aluB, vecs[i].eB);
            chk($sformatf("v%0d_store", i), outStoreData, vecs[i].eS);
            chk($sformatf("v%0d_ctrl", i), {16'b0, aluCtrl},
                {16'b0, vecs[i].ctrl});
        end
        inValid = 0; idle_fwd();
        tick();
        chk("drain_outValid", {31'b0, outValid}, 0);

        // back-to-back dependency through EX/MEM
        drive(32'h300, 5'd1, 5'd2, 5'd3, 32'h7, 32'h9, 0, 0, 0, 0);
        tick();
        drive(32'h304, 5'd3, 5'd3, 5'd4, 32'h0, 32'h0, 0, 0, 0, 0);
        #1;
        chk("b2b_noStall", {31'b0, inReady}, 1);
        tick();
        inValid = 0;
        exMemRegWrite = 1; exMemRdAddr = 5'd3; exMemResult = 32'h10;
        #1;
        chk("b2b_aluA", aluA, 32'h10);
        chk("b2b_aluB", aluB, 32'h10);
        idle_fwd();
        tick();

        // load-use stall
        drive(32'h400, 5'd1, 5'd0, 5'd5, 32'h0, 32'h0, 32'h4, 0, 1, 1);
        tick();
        drive(32'h404, 5'd5, 5'd6, 5'd7, 32'h0, 32'h6, 0, 0, 0, 0);
        #1;
        chk("lu_stall", {31'b0, inReady}, 0);
        tick();
        chk("lu_bubble", {31'b0, outValid}, 0);
        chk("lu_readyAgain", {31'b0, inReady}, 1);
        tick();
        inValid = 0;
        wbRegWrite = 1; wbRdAddr = 5'd5; wbResult = 32'hCAFE0000;
        #1;
        chk("lu_outValid", {31'b0, outValid}, 1);
        chk("lu_outPc", outPc, 32'h404);
        chk("lu_aluA", aluA, 32'hCAFE0000);
        idle_fwd();
        tick();

        // backpressure while producers retire
        drive(32'h500, 5'd7, 5'd1, 5'd8, 32'h0, 32'h1, 0, 0, 0, 0);
        tick();
        inValid = 0; outReady = 0;
        exMemRegWrite = 1; exMemRdAddr = 5'd7; exMemResult = 32'h55;
        tick();
        idle_fwd();
        wbRegWrite = 1; wbRdAddr = 5'd7; wbResult = 32'h55;
        tick();
        idle_fwd();
        tick();
        chk("bp_held", {31'b0, outValid}, 1);
        chk("bp_aluA", aluA, 32'h55);
        outReady = 1;
        tick();
        chk("bp_release", {31'b0, outValid}, 0);

        // flush with a hazard-causing input
        drive(32'h600, 5'd1, 5'd0, 5'd5, 32'h0, 32'h0, 32'h4, 0, 1, 1);
        tick();
        drive(32'h604, 5'd5, 5'd0, 5'd9, 32'h0, 32'h0, 0, 0, 0, 0);
        flush = 1;
        #1;
        chk("fl_hazard", {31'b0, inReady}, 0);
        tick();
        flush = 0; inValid = 0;
        chk("fl_outValid", {31'b0, outValid}, 0);
        chk("fl_notCaptured", outPc, 32'h600);

        // async reset during a hold
        drive(32'h700, 5'd3, 5'd4, 5'd6, 32'h31, 32'h41, 32'h9, 1, 1, 0);
        tick();
        inValid = 0; outReady = 0;
        tick();
        chk("rh_held", {31'b0, outValid}, 1);
        #2;
        rst = 1;
        #1;
        chk("rh_outValid", {31'b0, outValid}, 0);
        chk("rh_aluA", aluA, 0);
        chk("rh_aluB", aluB, 0);
        chk("rh_aluCtrl", {16'b0, aluCtrl}, 0);
        chk("rh_outPc", outPc, 0);
        chk("rh_store", outStoreData, 0);
        chk("rh_ctl", {27'b0, outRdAddr, outRegWrite,
                       outMemRead, outMemWrite}, 0);
        @(negedge clk);
        rst = 0; outReady = 1;
        drive(32'h800, 5'd1, 5'd2, 5'd3, 32'h12, 32'h34, 0, 0, 0, 0);
        tick();
        inValid = 0;
        chk("post_rst_valid", {31'b0, outValid}, 1);
        chk("post_rst_aluA", aluA, 32'h12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
